// File: rtl/fconv_pkg.sv
// Shared types and elaboration helpers for the sign/exponent/fraction converter.
package fconv_pkg;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } fconv_state_e;

  // Maximum normalising shift count (also the exponent of an unshifted sample).
  function automatic int unsigned fconv_lim(input int unsigned data_w, input int unsigned man_w);
    return data_w - man_w;
  endfunction

  // Legal width combination: 2 <= MAN_W < DATA_W-1 and 2^EXP_W-1 >= DATA_W-MAN_W-1.
  // The exponent inequality is rearranged as 2^EXP_W + MAN_W >= DATA_W to avoid unsigned underflow.
  function automatic bit fconv_cfg_ok(input int unsigned data_w, input int unsigned exp_w,
                                      input int unsigned man_w);
    return (man_w >= 32'd2) && (man_w + 32'd1 < data_w) &&
           ((32'd1 << exp_w) + man_w >= data_w);
  endfunction

endpackage

// File: rtl/fconv_if.sv
// Handshaked sample-in / float-out bus of the converter.
interface fconv_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned MAN_W  = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_s;
  logic [EXP_W-1:0]  out_e;
  logic [MAN_W-1:0]  out_f;
  logic              out_sat;

  // Sample source / result consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_s, out_e, out_f, out_sat
  );

  // Converter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_s, out_e, out_f, out_sat
  );

endinterface

// File: rtl/fconv_round.sv
// Rounding and exponent saturation stage of the converter (combinational).
// Build option: define FCONV_ROUND_EN for round-half-up; otherwise the fraction is truncated.
module fconv_round
  import fconv_pkg::*;
#(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 4
) (
  input  logic [EXP_W:0]   e_in,
  input  logic [MAN_W-1:0] f_in,
  input  logic             r_in,
  output logic [EXP_W-1:0] e_c,
  output logic [MAN_W-1:0] f_c,
  output logic             sat_c
);

  localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

  logic           inc;
  logic [MAN_W:0] sum;
  logic [EXP_W:0] e_r;
  logic [MAN_W-1:0] f_r;

`ifdef FCONV_ROUND_EN
  assign inc = r_in;
`else
  logic unused_r;
  assign inc      = 1'b0;
  assign unused_r = r_in;
`endif

  // Increment the fraction, renormalise on carry-out, then clamp the exponent range.
  always_comb begin
    sum   = {1'b0, f_in} + (MAN_W + 1)'(inc);
    e_r   = e_in;
    f_r   = sum[MAN_W-1:0];
    e_c   = '0;
    f_c   = '0;
    sat_c = 1'b0;
    if (sum[MAN_W]) begin
      f_r = sum[MAN_W:1];
      e_r = e_in + (EXP_W + 1)'(1);
    end
    if (e_r > E_MAX) begin
      e_c   = '1;
      f_c   = '1;
      sat_c = 1'b1;
    end else begin
      e_c   = e_r[EXP_W-1:0];
      f_c   = f_r;
    end
  end

endmodule

// File: rtl/fconv_seq.sv
// Iterative two's-complement to sign/exponent/fraction converter, one shift per cycle.
// Build option: FCONV_ROUND_EN selects round-half-up in fconv_round (default: truncate).
module fconv_seq
  import fconv_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned MAN_W  = 4
) (
  input logic    clk,
  input logic    rst,
  fconv_if.slave bus
);

  localparam int unsigned LIM  = fconv_lim(DATA_W, MAN_W);
  localparam int unsigned LZ_W = $clog2(LIM + 1);
  localparam int unsigned EW1  = EXP_W + 1;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W - 1){1'b0}}};

  if (!fconv_cfg_ok(DATA_W, EXP_W, MAN_W)) begin : g_cfg_err
    $error("fconv_seq: illegal DATA_W/EXP_W/MAN_W combination");
  end

  fconv_state_e      state, state_nxt;
  logic              sign_q, sign_nxt;
  logic [DATA_W-1:0] mag_q, mag_nxt;
  logic [LZ_W-1:0]   lz_q, lz_nxt;
  logic              out_s_q, out_s_nxt;
  logic [EXP_W-1:0]  out_e_q, out_e_nxt;
  logic [MAN_W-1:0]  out_f_q, out_f_nxt;
  logic              out_sat_q, out_sat_nxt;
  logic              in_ready_q, in_ready_nxt;
  logic              out_valid_q, out_valid_nxt;

  logic              accept;
  logic              is_most_neg;
  logic              norm_done;
  logic [EXP_W:0]    e_raw;
  logic [EXP_W-1:0]  rnd_e;
  logic [MAN_W-1:0]  rnd_f;
  logic              rnd_sat;

  assign accept      = bus.in_valid && in_ready_q;
  assign is_most_neg = (bus.in_data == MOST_NEG);
  assign norm_done   = mag_q[DATA_W-1] || (lz_q == LZ_W'(LIM));
  assign e_raw       = EW1'(LIM) - EW1'(lz_q);

  fconv_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .e_in  (e_raw),
    .f_in  (mag_q[DATA_W-1 -: MAN_W]),
    .r_in  (mag_q[DATA_W-1-MAN_W]),
    .e_c   (rnd_e),
    .f_c   (rnd_f),
    .sat_c (rnd_sat)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = is_most_neg ? DONE : NORM;
      NORM:    if (norm_done) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    sign_nxt      = sign_q;
    mag_nxt       = mag_q;
    lz_nxt        = lz_q;
    out_s_nxt     = out_s_q;
    out_e_nxt     = out_e_q;
    out_f_nxt     = out_f_q;
    out_sat_nxt   = out_sat_q;
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
    unique case (state)
      IDLE: begin
        if (accept) begin
          sign_nxt = bus.in_data[DATA_W-1];
          mag_nxt  = bus.in_data[DATA_W-1] ? (~bus.in_data + DATA_W'(1)) : bus.in_data;
          lz_nxt   = '0;
          if (is_most_neg) begin
            out_s_nxt   = 1'b1;
            out_e_nxt   = '1;
            out_f_nxt   = '1;
            out_sat_nxt = 1'b1;
          end
        end
      end
      NORM: begin
        if (!norm_done) begin
          mag_nxt = mag_q << 1;
          lz_nxt  = lz_q + LZ_W'(1);
        end else begin
          out_s_nxt   = sign_q;
          out_e_nxt   = rnd_e;
          out_f_nxt   = rnd_f;
          out_sat_nxt = rnd_sat;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q      <= 1'b0;
      mag_q       <= '0;
      lz_q        <= '0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_f_q     <= '0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      sign_q      <= sign_nxt;
      mag_q       <= mag_nxt;
      lz_q        <= lz_nxt;
      out_s_q     <= out_s_nxt;
      out_e_q     <= out_e_nxt;
      out_f_q     <= out_f_nxt;
      out_sat_q   <= out_sat_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_e     = out_e_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fconv_seq.sv
// Scoreboard bench for fconv_seq at the default 12/3/4 widths.
module tb_fconv_seq;

  typedef struct {
    logic s;
    int   e;
    int   f;
    logic sat;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  fconv_if #(.DATA_W(12), .EXP_W(3), .MAN_W(4)) bus ();

  fconv_seq #(.DATA_W(12), .EXP_W(3), .MAN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: cycle count here is edges from the accept edge to out_valid.
  function automatic exp_t model(input logic [11:0] d);
    exp_t x;
    int m, lz, r;
    x.s = d[11];
    x.sat = 1'b0;
    if (d == 12'h800) begin
      x.e = 7; x.f = 15; x.sat = 1'b1; x.lat = 0;
      return x;
    end
    m = d[11] ? 4096 - int'(d) : int'(d);
    lz = 0;
    while (lz < 8 && m < 2048) begin
      m = m * 2;
      lz++;
    end
    x.e = 8 - lz;
    x.f = m / 256;
    r = (m / 128) % 2;
`ifdef FCONV_ROUND_EN
    if (r == 1) begin
      x.f = x.f + 1;
      if (x.f == 16) begin
        x.f = 8;
        x.e = x.e + 1;
      end
    end
`else
    r = 0;
`endif
    if (x.e > 7) begin
      x.e = 7; x.f = 15; x.sat = 1'b1;
    end
    x.lat = lz + 1 + r * 0;
    return x;
  endfunction

  // Offer a sample until accepted; push its expected result.
  task automatic send(input logic [11:0] d, input exp_t x);
    bit done = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    sb.push_back(x);
  endtask

  // Wait for a result, compare against the scoreboard, optionally stall the consumer.
  task automatic recv(input int hold, input bit hold_valid);
    exp_t x;
    bit seen = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.out_valid) seen = 1;
      else @(negedge clk);
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    x = sb.pop_front();
    if (!seen) begin
      chk("out_timeout", 32'd0, 32'd1);
      return;
    end
    chk("lat", 32'(cyc - acc_cyc), 32'(x.lat));
    chk("s",   32'(bus.out_s),   32'(x.s));
    chk("e",   32'(bus.out_e),   32'(x.e));
    chk("f",   32'(bus.out_f),   32'(x.f));
    chk("sat", 32'(bus.out_sat), 32'(x.sat));
    if (hold_valid) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 12'h123;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_e",     32'(bus.out_e),     32'(x.e));
      chk("hold_f",     32'(bus.out_f),     32'(x.f));
      chk("hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_ready", 32'(bus.in_ready),  32'd1);
  endtask

  task automatic directed(input logic [11:0] d, input logic s, input int e, input int f,
                          input logic sat, input int lat);
    exp_t x;
    x.s = s; x.e = e; x.f = f; x.sat = sat; x.lat = lat;
    send(d, x);
    recv(0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    logic [11:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_s",     32'(bus.out_s),     32'd0);
    chk("rst_out_e",     32'(bus.out_e),     32'd0);
    chk("rst_out_f",     32'(bus.out_f),     32'd0);
    chk("rst_out_sat",   32'(bus.out_sat),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
`ifdef FCONV_ROUND_EN
    directed(12'h07D, 1'b0, 4, 4'b1000, 1'b0, 6);
    directed(12'hF83, 1'b1, 4, 4'b1000, 1'b0, 6);
    directed(12'h7FF, 1'b0, 7, 4'b1111, 1'b1, 2);
`else
    directed(12'h07D, 1'b0, 3, 4'b1111, 1'b0, 6);
    directed(12'hF83, 1'b1, 3, 4'b1111, 1'b0, 6);
    directed(12'h7FF, 1'b0, 7, 4'b1111, 1'b0, 2);
`endif
    directed(12'h800, 1'b1, 7, 4'b1111, 1'b1, 0);
    directed(12'h00A, 1'b0, 0, 4'b1010, 1'b0, 9);
    directed(12'h000, 1'b0, 0, 4'b0000, 1'b0, 9);
    directed(12'h001, 1'b0, 0, 4'b0001, 1'b0, 9);
    directed(12'hFFF, 1'b1, 0, 4'b0001, 1'b0, 9);
    directed(12'h400, 1'b0, 7, 4'b1000, 1'b0, 2);

    // Consumer stall with a new sample waiting.
    send(12'h07D, model(12'h07D));
    recv(5, 1'b1);

    // Asynchronous reset in the middle of normalisation.
    send(12'h001, model(12'h001));
    @(negedge clk);
    @(negedge clk);
    chk("norm_in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    send(12'hF83, model(12'hF83));
    recv(0, 1'b0);

    // Random samples with random consumer stalls.
    for (int i = 0; i < 24; i++) begin
      d = 12'($urandom_range(0, 4095));
      if (i == 0) d = 12'h800;
      x = model(d);
      send(d, x);
      recv(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
